brent_kung_adder: RTL and testbench

BRENT_KUNG_ADDER -- requirements
Module: brent_kung_adder

---
 rtl/brent_kung_pkg.sv | 32 +++
 rtl/bk_pg_cell.sv | 18 +
 rtl/brent_kung_adder.sv | 98 +++++++++
 tb/tb_brent_kung_adder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/brent_kung_pkg.sv
// brent_kung_pkg: shared constants and the node-placement helper for the
// Brent-Kung adder.
//   BK_WIDTH      default operand width
//   LOG2_WIDTH    up-sweep depth for the default width
//   node_present  reports whether a prefix level has a node at a bit index
//   node_offset   distance from a node to the lower group it combines with
// Prefix levels are numbered 1..L for the up-sweep, then L+1..2L-1 for the
// down-sweep, where L = log2(width).
package brent_kung_pkg;

    localparam int BK_WIDTH   = 32;
    localparam int LOG2_WIDTH = $clog2(BK_WIDTH);

    function automatic bit node_present(input int level, input int idx, input int log2w);
        int span;
        int dn;
        if (level >= 1 && level <= log2w) begin
            span = 1 << level;
            return ((idx + 1) % span) == 0;
        end
        dn   = 2 * log2w - level;
        span = 1 << dn;
        return (idx >= span) && (((idx + 1) % span) == (span >> 1));
    endfunction

    function automatic int node_offset(input int level, input int log2w);
        if (level <= log2w)
            return 1 << (level - 1);
        return 1 << (2 * log2w - level - 1);
    endfunction

endpackage

// File: rtl/bk_pg_cell.sv
// bk_pg_cell: black prefix cell. Merges a high group (gh, ph) with the
// adjacent lower group (gl, pl) into one group generate/propagate pair.
//   gh, ph  high-side group generate / propagate
//   gl, pl  low-side group generate / propagate
//   g, p    combined group generate / propagate
module bk_pg_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule

// File: rtl/brent_kung_adder.sv
// brent_kung_adder: WIDTH-bit adder with a Brent-Kung carry network and a
// single registered output stage (latency 1, one operation per cycle).
//   clk   clock, all state on rising edge
//   rst   synchronous active-high reset, clears every output register
//   a, b  addends (unsigned or two's complement)
//   cin   carry-in
//   sum   registered sum
//   cout  registered carry-out
//   ovf   registered signed overflow, only when BK_OVF_EN is defined
module brent_kung_adder
    import brent_kung_pkg::*;
#(
    parameter int WIDTH = BK_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BK_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LOG2W = $clog2(WIDTH);
    localparam int NLVL  = 2 * LOG2W - 1;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    // gs[l][i] / ps[l][i]: group terms ending at bit i after prefix level l.
    wire [WIDTH-1:0] gs [0:NLVL];
    wire [WIDTH-1:0] ps [0:NLVL];

    assign g = a & b;
    assign p = a ^ b;

    // cin acts as the generate of position -1, so bit 0 is merged with it
    // up front; every group afterwards already includes the carry-in.
    bk_pg_cell u_cin (
        .gh (g[0]),
        .ph (p[0]),
        .gl (cin),
        .pl (1'b0),
        .g  (gs[0][0]),
        .p  (ps[0][0])
    );

    if (WIDTH > 1) begin : g_lvl0
        assign gs[0][WIDTH-1:1] = g[WIDTH-1:1];
        assign ps[0][WIDTH-1:1] = p[WIDTH-1:1];
    end

    for (genvar l = 1; l <= NLVL; l++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (node_present(l, i, LOG2W)) begin : g_node
                bk_pg_cell u_cell (
                    .gh (gs[l-1][i]),
                    .ph (ps[l-1][i]),
                    .gl (gs[l-1][i-node_offset(l, LOG2W)]),
                    .pl (ps[l-1][i-node_offset(l, LOG2W)]),
                    .g  (gs[l][i]),
                    .p  (ps[l][i])
                );
            end else begin : g_pass
                assign gs[l][i] = gs[l-1][i];
                assign ps[l][i] = ps[l-1][i];
            end
        end
    end

    assign c[0]       = cin;
    assign c[WIDTH:1] = gs[NLVL];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= p ^ c[WIDTH-1:0];
            cout <= c[WIDTH];
        end
    end

`ifdef BK_OVF_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else
            ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
`endif

endmodule

// File: tb/tb_brent_kung_adder.sv
// tb_brent_kung_adder: directed vectors with literal expectations plus a
// long random stream checked every cycle against an arithmetic model.
// Overflow checks are compiled in when BK_OVF_EN is defined.
module tb_brent_kung_adder;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic [W-1:0]  sum;
    logic          cout;
`ifdef BK_OVF_EN
    logic          ovf;
`endif

    int tests = 0;
    int fails = 0;

    logic [W:0]    exp_res = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_valid = 1'b0;

    brent_kung_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
`ifdef BK_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Model: what the outputs must hold after this edge.
    always @(posedge clk) begin
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        exp_valid <= 1'b1;
        if (rst) begin
            exp_res <= '0;
            exp_ovf <= 1'b0;
        end else begin
            exp_res <= r;
            exp_ovf <= (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            tests++;
            if ({cout, sum} !== exp_res) begin
                fails++;
                $display("FAIL model_cmp t=%0t got cout=%0b sum=%08h want cout=%0b sum=%08h",
                         $time, cout, sum, exp_res[W], exp_res[W-1:0]);
            end
`ifdef BK_OVF_EN
            tests++;
            if (ovf !== exp_ovf) begin
                fails++;
                $display("FAIL model_ovf t=%0t got %0b want %0b", $time, ovf, exp_ovf);
            end
`endif
        end
    end

    task automatic lit(input string name, input logic [W-1:0] es, input logic ec);
        tests++;
        if (sum !== es || cout !== ec) begin
            fails++;
            $display("FAIL %s got cout=%0b sum=%08h want cout=%0b sum=%08h",
                     name, cout, sum, ec, es);
        end
    endtask

`ifdef BK_OVF_EN
    task automatic lit_ovf(input string name, input logic eo);
        tests++;
        if (ovf !== eo) begin
            fails++;
            $display("FAIL %s_ovf got %0b want %0b", name, ovf, eo);
        end
    endtask
`endif

    task automatic apply(input logic r, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc);
        rst = r;
        a   = va;
        b   = vb;
        cin = vc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        @(negedge clk);

        apply(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        lit("reset_dominates", 32'h0000_0000, 1'b0);
`ifdef BK_OVF_EN
        lit_ovf("reset_dominates", 1'b0);
`endif
        apply(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1);
        lit("zero_plus_cin", 32'h0000_0001, 1'b0);
        apply(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        lit("wrap_around", 32'h0000_0000, 1'b1);
        apply(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        lit("mixed_pattern", 32'hACF1_3569, 1'b0);
        apply(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        lit("all_ones_cin", 32'hFFFF_FFFF, 1'b1);
        apply(1'b0, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0);
        lit("alternating", 32'hFFFF_FFFF, 1'b0);
        apply(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        lit("half_carry", 32'h0001_0000, 1'b0);
        apply(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        lit("pos_overflow", 32'h8000_0000, 1'b0);
`ifdef BK_OVF_EN
        lit_ovf("pos_overflow", 1'b1);
`endif
        apply(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        lit("neg_overflow", 32'h0000_0000, 1'b1);
`ifdef BK_OVF_EN
        lit_ovf("neg_overflow", 1'b1);
`endif
        apply(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1);
        lit("reset_mid", 32'h0000_0000, 1'b0);
        apply(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0);
        lit("first_after_reset", 32'h0000_0007, 1'b0);

        for (int n = 0; n < 10000; n++) begin
            logic r;
            r = (n == 3000) || (n == 7000) || (n == 7001);
            apply(r, W'($urandom), W'($urandom), n[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
